// File: rtl/fmq_pkg.sv
// fmq_pkg: opcodes, frame layout, FSM state type and the command framing function
package fmq_pkg;
  localparam logic [1:0] OP_SET_OFFSET = 2'd0;
  localparam logic [1:0] OP_RELOAD = 2'd1;
  localparam logic [1:0] OP_QUERY_OUTPUTS = 2'd2;
  localparam logic [1:0] OP_ECHO_ZERO = 2'd3;
  localparam int BYTE_W = 8;
  localparam int FRAME_BITS = 3 * BYTE_W;
  localparam int SYNC_BIT = 7;
  localparam int B0_LSB = 2 * BYTE_W;
  localparam int B1_LSB = BYTE_W;
  localparam int B2_LSB = 0;
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT_RSP} state_t;
  // Only B0 carries the sync bit, so a receiver can realign after a truncated frame.
  function automatic logic [FRAME_BITS-1:0] fmq_frame(input logic [1:0] op, input logic [7:0] addr,
                                                      input logic [10:0] offset);
    return {1'b1, op, addr[7:3], 1'b0, addr[2:0], offset[10:7], 1'b0, offset[6:0]};
  endfunction
endpackage

// File: rtl/fmq_cmd_encoder_if.sv
// fmq_cmd_encoder_if: command, UART byte stream and response signals of the encoder
// master drives cmd_*, m_axis_tready and s_axis_t{data,valid}; slave (the encoder) drives the rest.
interface fmq_cmd_encoder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int OFFSET_WIDTH = 11
);
  logic [1:0] cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [OFFSET_WIDTH-1:0] cmd_offset;
  logic cmd_valid;
  logic cmd_ready;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic [7:0] rsp_data;
  logic rsp_valid;
  logic rsp_timeout;
  logic busy;
  modport master (
    output cmd_op, cmd_addr, cmd_offset, cmd_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    input cmd_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready, rsp_data, rsp_valid, rsp_timeout, busy
  );
  modport slave (
    input cmd_op, cmd_addr, cmd_offset, cmd_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    output cmd_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready, rsp_data, rsp_valid, rsp_timeout, busy
  );
endinterface

// File: rtl/fmq_cmd_encoder.sv
// fmq_cmd_encoder: frames commands into 3 UART bytes and waits for an optional 1-byte response
// clk: system clock; rst: async active-low reset; bus: command in, byte stream out/in, response out.
module fmq_cmd_encoder
  import fmq_pkg::*;
#(
  parameter int OFFSET_WIDTH = 11,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst,
  fmq_cmd_encoder_if.slave bus
);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic [FRAME_BITS-1:0] frame;
  assign frame = fmq_frame(op_q, addr_q, offset_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      offset_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      offset_q <= offset_d;
      cnt_q <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    offset_d = offset_q;
    cnt_d = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d = bus.cmd_op;
        addr_d = bus.cmd_addr;
        offset_d = bus.cmd_offset;
        state_d = SEND0;
      end
      SEND0: state_d = bus.m_axis_tready ? SEND1 : SEND0;
      SEND1: state_d = bus.m_axis_tready ? SEND2 : SEND1;
      SEND2: if (bus.m_axis_tready) begin
        state_d = op_q[1] ? WAIT_RSP : IDLE;
        cnt_d = '0;
      end
      // A byte arriving on the last wait cycle still wins over the timeout.
      WAIT_RSP: if (bus.s_axis_tvalid) begin
        rsp_data_d = bus.s_axis_tdata;
        rsp_valid_d = 1'b1;
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        rsp_timeout_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Gating with rst keeps cmd_ready low while reset is held, yet high right after release.
  assign bus.cmd_ready = rst && state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.m_axis_tvalid = state_q inside {SEND0, SEND1, SEND2};
  assign bus.m_axis_tdata = state_q == SEND0 ? frame[B0_LSB+:BYTE_W] :
                            state_q == SEND1 ? frame[B1_LSB+:BYTE_W] :
                            state_q == SEND2 ? frame[B2_LSB+:BYTE_W] : '0;
  assign bus.s_axis_tready = 1'b1;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_fmq_cmd_encoder.sv
// tb_fmq_cmd_encoder: directed and random checks of fmq_cmd_encoder against an arithmetic frame model
module tb_fmq_cmd_encoder;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;
  int t_at, t_cnt, big_ev;
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] exp_rd_t = 8'h00;
  fmq_cmd_encoder_if bus ();
  fmq_cmd_encoder_if bus_t ();
  fmq_cmd_encoder dut (.clk(clk), .rst(rst_n), .bus(bus));
  fmq_cmd_encoder #(.TIMEOUT_CYCLES(TO)) dut_t (.clk(clk), .rst(rst_n), .bus(bus_t));
  assign bus_t.cmd_op = bus.cmd_op;
  assign bus_t.cmd_addr = bus.cmd_addr;
  assign bus_t.cmd_offset = bus.cmd_offset;
  assign bus_t.cmd_valid = bus.cmd_valid;
  assign bus_t.m_axis_tready = bus.m_axis_tready;
  assign bus_t.s_axis_tdata = bus.s_axis_tdata;
  assign bus_t.s_axis_tvalid = bus.s_axis_tvalid;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog expired");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Byte n of the frame from plain arithmetic on the field values.
  function automatic logic [7:0] model_byte(input int n, input int op, input int addr, input int off);
    if (n == 0) return 8'(128 + op * 32 + addr / 8);
    if (n == 1) return 8'((addr % 8) * 16 + off / 128);
    return 8'(off % 128);
  endfunction
  task automatic do_cmd(input int op, input int addr, input int off, input int stall);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_op = 2'(op);
    bus.cmd_addr = 8'(addr);
    bus.cmd_offset = 11'(off);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("busy_in_frame", bus.busy, 1);
    check("cmd_ready_in_frame", bus.cmd_ready, 0);
    for (int b = 0; b < 3; b++) begin
      if (b == 1 && stall > 0) begin
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < stall; i++) begin
          check("stall_tvalid", bus.m_axis_tvalid, 1);
          check("stall_tdata", bus.m_axis_tdata, model_byte(1, op, addr, off));
          step();
        end
        bus.m_axis_tready = 1'b1;
      end
      check("tvalid", bus.m_axis_tvalid, 1);
      check($sformatf("tdata_b%0d", b), bus.m_axis_tdata, model_byte(b, op, addr, off));
      check($sformatf("tdata_t_b%0d", b), bus_t.m_axis_tdata, model_byte(b, op, addr, off));
      step();
    end
    check("tvalid_after_b2", bus.m_axis_tvalid, 0);
    if (op < 2) begin
      check("ready_after_b2", bus.cmd_ready, 1);
      check("busy_after_b2", bus.busy, 0);
    end else begin
      check("wait_busy", bus.busy, 1);
      check("wait_not_ready", bus.cmd_ready, 0);
      check("wait_t_busy", bus_t.busy, 1);
    end
  endtask
  task automatic do_rsp(input int dly, input logic [7:0] d, input bit t_live);
    for (int i = 0; i < dly; i++) begin
      check("no_early_rsp", bus.rsp_valid, 0);
      step();
    end
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = d;
    step();
    bus.s_axis_tvalid = 1'b0;
    exp_rd = d;
    if (t_live) exp_rd_t = d;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_data", bus.rsp_data, exp_rd);
    check("rsp_timeout_low", bus.rsp_timeout, 0);
    check("ready_after_rsp", bus.cmd_ready, 1);
    check("rsp_valid_t", bus_t.rsp_valid, t_live);
    check("rsp_timeout_t_low", bus_t.rsp_timeout, 0);
    check("rsp_data_t", bus_t.rsp_data, exp_rd_t);
    step();
    check("rsp_valid_one_cycle", bus.rsp_valid, 0);
    check("rsp_data_held", bus.rsp_data, exp_rd);
    check("rsp_valid_t_one_cycle", bus_t.rsp_valid, 0);
  endtask
  task automatic watch_timeout(input int cycles);
    t_at = -1;
    t_cnt = 0;
    big_ev = 0;
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (bus_t.rsp_timeout) begin
        t_cnt++;
        if (t_at < 0) t_at = i;
      end
      if (bus.rsp_valid || bus.rsp_timeout || bus_t.rsp_valid) big_ev++;
    end
    check("timeout_cycle", t_at, TO);
    check("timeout_pulses", t_cnt, 1);
    check("no_other_events", big_ev, 0);
    check("rsp_data_t_kept_on_timeout", bus_t.rsp_data, exp_rd_t);
    check("t_idle_after_timeout", bus_t.busy, 0);
    check("big_still_waiting", bus.busy, 1);
  endtask
  initial begin
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_offset = '0;
    bus.cmd_valid = 1'b0;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_s_tready", bus.s_axis_tready, 1);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", bus.cmd_ready, 1);
    step();
    do_cmd(0, 5, 'h2A3, 0);
    do_cmd(2, $urandom_range(0, 255), $urandom_range(0, 2047), 0);
    do_rsp(TO - 1, 8'hA7, 1);
    do_cmd(2, 0, 0, 0);
    watch_timeout(499);
    do_rsp(0, 8'h10, 0);
    do_cmd(3, $urandom_range(0, 255), $urandom_range(0, 2047), 0);
    watch_timeout(120);
    do_rsp(0, 8'($urandom), 0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = 8'h55;
    step();
    bus.s_axis_tvalid = 1'b0;
    check("stray_rsp_valid", bus.rsp_valid, 0);
    check("stray_rsp_data", bus.rsp_data, exp_rd);
    check("stray_rsp_valid_t", bus_t.rsp_valid, 0);
    check("stray_busy", bus.busy, 0);
    step();
    check("stray_rsp_valid_late", bus.rsp_valid, 0);
    do_cmd($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 2047), 10);
    bus.cmd_op = 2'd0;
    bus.cmd_addr = 8'h12;
    bus.cmd_offset = 11'h345;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("partial_b1", bus.m_axis_tdata, model_byte(1, 0, 'h12, 'h345));
    rst_n = 1'b0;
    #1;
    exp_rd = 8'h00;
    exp_rd_t = 8'h00;
    check("midrst_tvalid", bus.m_axis_tvalid, 0);
    check("midrst_tdata", bus.m_axis_tdata, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ready", bus.cmd_ready, 0);
    check("midrst_rsp_data", bus.rsp_data, exp_rd);
    step();
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", bus.cmd_ready, 1);
    do_cmd(1, 'hFF, 0, 0);
    for (int k = 0; k < 20; k++) begin
      int op;
      op = $urandom_range(0, 3);
      do_cmd(op, $urandom_range(0, 255), $urandom_range(0, 2047), $urandom_range(0, 3));
      if (op >= 2) do_rsp($urandom_range(0, 50), 8'($urandom), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
